// File: rtl/token_sched_pkg.sv
// Shared constants and types for the token thinner/scheduler.
// Defaults here seed the top-level parameters.
package token_sched_pkg;

  localparam int N_CH_DEFAULT    = 4;
  localparam int DIV_RST_DEFAULT = 2;
  localparam int CH_W_DEFAULT    = $clog2(N_CH_DEFAULT);

  typedef logic [CH_W_DEFAULT-1:0] ch_sel_t;

endpackage

// File: rtl/token_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping around, as one-hot and index.
module token_rr_arbiter
  import token_sched_pkg::*;
#(
  parameter int N = N_CH_DEFAULT
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = $clog2(N)'(j);
      end
    end
  end

endmodule

// File: rtl/token_thin_scheduler.sv
// Per-channel 1-of-DIV token thinning, saturating pending counters
// and a round-robin single-entry valid/ready output stage.
module token_thin_scheduler
  import token_sched_pkg::*;
#(
  parameter int N_CH    = N_CH_DEFAULT,
  parameter int DIV_W   = 4,
  parameter int CNT_W   = 4,
  parameter int DIV_RST = DIV_RST_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         tok_i,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic [N_CH-1:0]         drop_o,
  output logic                    busy
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  logic [DIV_W-1:0] div_q  [N_CH];
  logic [DIV_W-1:0] ph_q   [N_CH];
  logic [CNT_W-1:0] pend_q [N_CH];

  logic [N_CH-1:0] req;
  logic [N_CH-1:0] keep;
  logic [N_CH-1:0] dec;
  logic [N_CH-1:0] cfg_hit;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W-1:0] rr_ptr;
  logic            gnt_any;
  logic            load;

  assign load = !out_valid || out_ready;
  assign busy = out_valid || (|req);

  always_comb begin
    req     = '0;
    keep    = '0;
    dec     = '0;
    cfg_hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      req[c]     = |pend_q[c];
      keep[c]    = tok_i[c] && (div_q[c] != '0) &&
                   (ph_q[c] == div_q[c] - DIV_W'(1));
      dec[c]     = load && gnt[c];
      cfg_hit[c] = cfg_we && (int'(cfg_ch) == c);
    end
  end

  token_rr_arbiter #(
    .N(N_CH)
  ) u_arb (
    .req(req),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        div_q[c]  <= DIV_W'(DIV_RST);
        ph_q[c]   <= '0;
        pend_q[c] <= '0;
      end
      drop_o    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        // keep uses the old div even when a config write lands this cycle
        if (cfg_hit[c]) begin
          div_q[c] <= cfg_div;
          ph_q[c]  <= '0;
        end else if (tok_i[c] && div_q[c] != '0) begin
          ph_q[c] <= keep[c] ? '0 : ph_q[c] + DIV_W'(1);
        end
        drop_o[c] <= 1'b0;
        case ({keep[c], dec[c]})
          2'b10: begin
            if (pend_q[c] == PEND_MAX) drop_o[c] <= 1'b1;
            else                       pend_q[c] <= pend_q[c] + CNT_W'(1);
          end
          2'b01:   pend_q[c] <= pend_q[c] - CNT_W'(1);
          default: ;
        endcase
      end
      if (load) begin
        out_valid <= gnt_any;
        if (gnt_any) begin
          out_ch <= gnt_idx;
          rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
        end
      end
    end
  end

endmodule
